// File: rtl/aukv_lsu.sv
// aukv_lsu - load/store unit for the Auk-V memory-access stage.
//
// Takes one memory op at a time from execute, steers store data and byte
// strobes onto an XLEN-wide data bus, runs a req/gnt/rvalid handshake,
// extracts and extends load data for writeback, and reports misaligned
// accesses, bus errors and response timeouts as one-cycle exceptions.
//
// Parameters: XLEN (32 or 64), TIMEOUT (cycles from issue to response, >= 2).
//
// Ports:
//   i_clk, i_rstn                  clock, async active-low reset
//   i_req_*, i_addr, i_wdata,
//   i_ld_type, i_st_type, i_rd     op from execute
//   i_flush                        kill the accepted / in-flight op
//   o_stall                        unit busy (combinational)
//   o_dmem_*, i_dmem_*             data-memory bus
//   o_wb_*                         load result to writeback
//   o_exc_*                        exception pulse, cause, faulting address
//
// Build option: AUKV_LSU_MISALIGN_TRAP_EN - when defined, misaligned
// accesses trap (cause 01 load / 10 store) instead of being issued with
// their low address bits forced to the access size.
//
// state | meaning
// IDLE  | ready; accepts an op when valid and not flushed
// REQ   | request on the bus, waiting for grant
// WAIT  | granted, waiting for the response
// DRAIN | op was flushed after grant; swallow its one response
module aukv_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_req_valid,
  input  logic              i_req_we,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [2:0]        i_ld_type,
  input  logic [1:0]        i_st_type,
  input  logic [4:0]        i_rd,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [XLEN-1:0]   o_dmem_addr,
  output logic [XLEN-1:0]   o_dmem_wdata,
  output logic [XLEN/8-1:0] o_dmem_strb,
  input  logic              i_dmem_gnt,
  input  logic              i_dmem_rvalid,
  input  logic [XLEN-1:0]   i_dmem_rdata,
  input  logic              i_dmem_err,
  output logic              o_wb_valid,
  output logic [4:0]        o_wb_rd,
  output logic [XLEN-1:0]   o_wb_data,
  output logic              o_exc_valid,
  output logic [1:0]        o_exc_cause,
  output logic [XLEN-1:0]   o_exc_addr
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t state, state_nxt;

  logic [1:0]      req_size;
  logic            req_uns;
  logic [OB-1:0]   low_mask;
  logic [OB-1:0]   req_off;
  logic [NB-1:0]   strb_base;
  logic [NB-1:0]   req_strb;
  logic [XLEN-1:0] req_wdata;
  logic            accept;
  logic            trap;
  logic            done;
  logic            tmo;
  logic            cnt_tc;

  logic            op_we;
  logic [1:0]      op_size;
  logic            op_uns;
  logic [OB-1:0]   op_off;
  logic [4:0]      op_rd;
  logic [XLEN-1:0] op_addr;
  logic [CW-1:0]   cnt;

  // Access size as log2(bytes); illegal encodings collapse to word.
  always_comb begin
    if (i_req_we) begin
      req_size = i_st_type;
      if (XLEN == 32 && i_st_type == 2'd3) req_size = 2'd2;
    end else begin
      req_size = i_ld_type[1:0];
      if (req_size == 2'd3 && (XLEN == 32 || i_ld_type[2])) req_size = 2'd2;
    end
  end

  assign req_uns = ~i_req_we & i_ld_type[2];

  always_comb begin
    case (req_size)
      2'd0:    begin low_mask = '0;       strb_base = NB'(1);   end
      2'd1:    begin low_mask = OB'(1);   strb_base = NB'(3);   end
      2'd2:    begin low_mask = OB'(3);   strb_base = NB'(15);  end
      default: begin low_mask = OB'(7);   strb_base = NB'(255); end
    endcase
  end

  // Offset with the bits below the access size dropped (natural alignment).
  assign req_off  = i_addr[OB-1:0] & ~low_mask;
  assign req_strb = strb_base << req_off;

  always_comb begin
    case (req_size)
      2'd0:    req_wdata = {NB{i_wdata[7:0]}};
      2'd1:    req_wdata = {(NB/2){i_wdata[15:0]}};
      2'd2:    req_wdata = {(NB/4){i_wdata[31:0]}};
      default: req_wdata = i_wdata;
    endcase
  end

  assign accept = (state == IDLE) & i_req_valid & ~i_flush;

`ifdef AUKV_LSU_MISALIGN_TRAP_EN
  assign trap = accept & (|(i_addr[OB-1:0] & low_mask));
`else
  assign trap = 1'b0;
`endif

  assign cnt_tc  = (cnt == CW'(TIMEOUT - 1));
  assign o_stall = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  // A flush always beats a timeout; once granted, a flushed op must still
  // see its response go by (DRAIN), unless it arrives in the flush cycle.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !trap) state_nxt = REQ;
      end
      REQ: begin
        if (i_flush) begin
          if (i_dmem_gnt && !i_dmem_rvalid) state_nxt = DRAIN;
          else                              state_nxt = IDLE;
        end else if (i_dmem_gnt && i_dmem_rvalid) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (cnt_tc) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end else if (i_dmem_gnt) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (i_flush) begin
          state_nxt = i_dmem_rvalid ? IDLE : DRAIN;
        end else if (i_dmem_rvalid) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (cnt_tc) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (i_dmem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  function automatic logic [XLEN-1:0] load_extract(
    input logic [XLEN-1:0] rdata,
    input logic [OB-1:0]   off,
    input logic [1:0]      size,
    input logic            uns
  );
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'd0: begin
        res = XLEN'(sh[7:0]);
        if (!uns && sh[7]) res = res | ~XLEN'(8'hFF);
      end
      2'd1: begin
        res = XLEN'(sh[15:0]);
        if (!uns && sh[15]) res = res | ~XLEN'(16'hFFFF);
      end
      2'd2: begin
        res = XLEN'(sh[31:0]);
        if (!uns && sh[31]) res = res | ~XLEN'(32'hFFFF_FFFF);
      end
      default: res = sh;
    endcase
    return res;
  endfunction

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      o_dmem_strb  <= '0;
      o_wb_valid   <= 1'b0;
      o_wb_rd      <= '0;
      o_wb_data    <= '0;
      o_exc_valid  <= 1'b0;
      o_exc_cause  <= '0;
      o_exc_addr   <= '0;
      op_we        <= 1'b0;
      op_size      <= '0;
      op_uns       <= 1'b0;
      op_off       <= '0;
      op_rd        <= '0;
      op_addr      <= '0;
      cnt          <= '0;
    end else begin
      o_dmem_req  <= (state_nxt == REQ);
      o_wb_valid  <= done & ~op_we & ~i_dmem_err;
      o_exc_valid <= trap | tmo | (done & i_dmem_err);

      if (trap) begin
        o_exc_cause <= i_req_we ? 2'b10 : 2'b01;
        o_exc_addr  <= i_addr;
      end else if (tmo || (done && i_dmem_err)) begin
        o_exc_cause <= 2'b11;
        o_exc_addr  <= op_addr;
      end

      if (done && !op_we && !i_dmem_err) begin
        o_wb_rd   <= op_rd;
        o_wb_data <= load_extract(i_dmem_rdata, op_off, op_size, op_uns);
      end

      if (accept && !trap) begin
        op_we        <= i_req_we;
        op_size      <= req_size;
        op_uns       <= req_uns;
        op_off       <= req_off;
        op_rd        <= i_rd;
        op_addr      <= i_addr;
        o_dmem_we    <= i_req_we;
        o_dmem_addr  <= {i_addr[XLEN-1:OB], {OB{1'b0}}};
        o_dmem_wdata <= req_wdata;
        o_dmem_strb  <= req_strb;
      end

      if (accept)                              cnt <= '0;
      else if (state == REQ || state == WAIT)  cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_aukv_lsu.sv
`timescale 1ns/1ps
module tb_aukv_lsu;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 4;
  localparam int NB      = XLEN / 8;

  logic              i_clk = 1'b0;
  logic              i_rstn = 1'b0;
  logic              i_req_valid = 1'b0;
  logic              i_req_we = 1'b0;
  logic [XLEN-1:0]   i_addr = '0;
  logic [XLEN-1:0]   i_wdata = '0;
  logic [2:0]        i_ld_type = '0;
  logic [1:0]        i_st_type = '0;
  logic [4:0]        i_rd = '0;
  logic              i_flush = 1'b0;
  logic              o_stall;
  logic              o_dmem_req;
  logic              o_dmem_we;
  logic [XLEN-1:0]   o_dmem_addr;
  logic [XLEN-1:0]   o_dmem_wdata;
  logic [NB-1:0]     o_dmem_strb;
  logic              i_dmem_gnt = 1'b0;
  logic              i_dmem_rvalid = 1'b0;
  logic [XLEN-1:0]   i_dmem_rdata = '0;
  logic              i_dmem_err = 1'b0;
  logic              o_wb_valid;
  logic [4:0]        o_wb_rd;
  logic [XLEN-1:0]   o_wb_data;
  logic              o_exc_valid;
  logic [1:0]        o_exc_cause;
  logic [XLEN-1:0]   o_exc_addr;

  aukv_lsu #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_req_valid(i_req_valid), .i_req_we(i_req_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_ld_type(i_ld_type), .i_st_type(i_st_type),
    .i_rd(i_rd), .i_flush(i_flush), .o_stall(o_stall),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_strb(o_dmem_strb),
    .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid),
    .i_dmem_rdata(i_dmem_rdata), .i_dmem_err(i_dmem_err),
    .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
    .o_exc_valid(o_exc_valid), .o_exc_cause(o_exc_cause), .o_exc_addr(o_exc_addr)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Result expected to be visible in the first idle cycle after an op.
  logic            exp_wb = 1'b0;
  logic            exp_exc = 1'b0;
  logic [4:0]      exp_rd = '0;
  logic [XLEN-1:0] exp_data = '0;
  logic [1:0]      exp_cause = '0;
  logic [XLEN-1:0] exp_eaddr = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int acc_bytes(input logic we, input logic [2:0] ldt, input logic [1:0] stt);
    int b;
    b = 4;
    if (we) begin
      case (stt)
        2'd0: b = 1;
        2'd1: b = 2;
        2'd3: b = (XLEN == 64) ? 8 : 4;
        default: b = 4;
      endcase
    end else begin
      case (ldt)
        3'd0, 3'd4: b = 1;
        3'd1, 3'd5: b = 2;
        3'd3:       b = (XLEN == 64) ? 8 : 4;
        default:    b = 4;
      endcase
    end
    return b;
  endfunction

  function automatic logic [NB-1:0] ref_strb(input int off, input int bytes);
    logic [NB-1:0] s;
    for (int i = 0; i < NB; i++) s[i] = (i >= off) && (i < off + bytes);
    return s;
  endfunction

  function automatic logic [XLEN-1:0] ref_wdata(input logic [XLEN-1:0] wd, input int bytes);
    logic [XLEN-1:0] w;
    for (int i = 0; i < NB; i++) w[8*i +: 8] = wd[8*(i % bytes) +: 8];
    return w;
  endfunction

  function automatic logic [XLEN-1:0] ref_load(input logic [XLEN-1:0] rdata, input int off,
                                                input int bytes, input bit sgn);
    logic [63:0] v;
    logic [63:0] mask;
    v = 64'(rdata) >> (8 * off);
    mask = (bytes == 8) ? '1 : ((64'd1 << (8 * bytes)) - 64'd1);
    v = v & mask;
    if (sgn && v[8*bytes-1]) v = v | ~mask;
    return v[XLEN-1:0];
  endfunction

  task automatic check_idle();
    check("stall_idle", o_stall, 0);
    check("req_idle", o_dmem_req, 0);
    check("wb_valid", o_wb_valid, exp_wb);
    check("exc_valid", o_exc_valid, exp_exc);
    if (exp_wb) begin
      check("wb_rd", o_wb_rd, exp_rd);
      check("wb_data", o_wb_data, exp_data);
    end
    if (exp_exc) begin
      check("exc_cause", o_exc_cause, exp_cause);
      check("exc_addr", o_exc_addr, exp_eaddr);
    end
    exp_wb  = 1'b0;
    exp_exc = 1'b0;
  endtask

  task automatic idle_cycle();
    check_idle();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // g: grant delay after request appears; r: response delay after grant;
  // kf: cycle of a flush while busy (-1 = none); idle_flush: flush in accept cycle.
  task automatic run_op(input logic we, input logic [2:0] ldt, input logic [1:0] stt,
                        input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wdata,
                        input logic [XLEN-1:0] rdata, input logic [4:0] rd,
                        input int g, input int r, input int kf, input logic err,
                        input logic idle_flush);
    int bytes;
    int off;
    int resp_k;
    int kend;
    int req_last;
    bit timeout;
    check_idle();
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_addr      = addr;
    i_wdata     = wdata;
    i_ld_type   = ldt;
    i_st_type   = stt;
    i_rd        = rd;
    i_flush     = idle_flush;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    i_flush     = 1'b0;
    i_req_we    = 1'($urandom);
    i_addr      = $urandom;
    i_wdata     = $urandom;
    i_ld_type   = 3'($urandom);
    i_st_type   = 2'($urandom);
    i_rd        = 5'($urandom);
    if (idle_flush) return;

    bytes = acc_bytes(we, ldt, stt);
    off   = int'(addr % NB);
`ifdef AUKV_LSU_MISALIGN_TRAP_EN
    if ((off % bytes) != 0) begin
      exp_exc   = 1'b1;
      exp_cause = we ? 2'b10 : 2'b01;
      exp_eaddr = addr;
      return;
    end
`endif
    off = off - (off % bytes);

    resp_k  = g + r;
    timeout = 1'b0;
    if (kf >= 0 && kf < g)          kend = kf;
    else if (kf >= 0)               kend = resp_k;
    else if (resp_k > TIMEOUT - 1) begin
      timeout = 1'b1;
      kend    = TIMEOUT - 1;
    end else                        kend = resp_k;
    req_last = (g < TIMEOUT - 1) ? g : TIMEOUT - 1;
    if (kf >= 0 && kf < req_last) req_last = kf;

    for (int k = 0; k <= kend; k++) begin
      check("stall_busy", o_stall, 1);
      check("wb_quiet", o_wb_valid, 0);
      check("exc_quiet", o_exc_valid, 0);
      check("req", o_dmem_req, k <= req_last);
      if (k <= req_last) begin
        check("bus_addr", o_dmem_addr, addr & ~XLEN'(NB - 1));
        check("bus_we", o_dmem_we, we);
        check("bus_strb", o_dmem_strb, ref_strb(off, bytes));
        if (we) check("bus_wdata", o_dmem_wdata, ref_wdata(wdata, bytes));
      end
      i_dmem_gnt    = (k == g);
      i_dmem_rvalid = (k == resp_k);
      i_dmem_err    = (k == resp_k) ? err : 1'($urandom);
      i_dmem_rdata  = (k == resp_k) ? rdata : XLEN'($urandom);
      i_flush       = (k == kf);
      @(posedge i_clk);
      @(negedge i_clk);
    end
    i_dmem_gnt    = 1'b0;
    i_dmem_rvalid = 1'b0;
    i_flush       = 1'b0;

    if (timeout) begin
      exp_exc   = 1'b1;
      exp_cause = 2'b11;
      exp_eaddr = addr;
    end else if (kf < 0) begin
      if (err) begin
        exp_exc   = 1'b1;
        exp_cause = 2'b11;
        exp_eaddr = addr;
      end else if (!we) begin
        exp_wb   = 1'b1;
        exp_rd   = rd;
        exp_data = ref_load(rdata, off, bytes, ldt < 3'd4);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    check("rst_stall", o_stall, 0);
    check("rst_req", o_dmem_req, 0);
    check("rst_wb_valid", o_wb_valid, 0);
    check("rst_exc_valid", o_exc_valid, 0);
    check("rst_strb", o_dmem_strb, 0);
    check("rst_wb_data", o_wb_data, 0);
    i_rstn = 1'b1;
    @(negedge i_clk);

    // LB at top lane, sign extended, zero-wait
    run_op(0, 3'd0, 2'd0, 32'h1003, 32'h0, 32'h80FF_FFFF, 5'd3, 0, 0, -1, 0, 0);
    // SH upper half, grant 3 cycles late, response with grant
    run_op(1, 3'd0, 2'd1, 32'h2002, 32'h0000_BEEF, 32'h0, 5'd0, 3, 0, -1, 0, 0);
    // load flushed in WAIT, drained two cycles later, next op back-to-back
    run_op(0, 3'd2, 2'd0, 32'h3000, 32'h0, 32'hDEAD_BEEF, 5'd7, 0, 3, 1, 0, 0);
    run_op(0, 3'd5, 2'd0, 32'h4002, 32'h0, 32'h8001_1234, 5'd9, 0, 0, -1, 0, 0);
    // granted but no response: timeout
    run_op(0, 3'd2, 2'd0, 32'h5004, 32'h0, 32'h0, 5'd1, 0, 9, -1, 0, 0);
    // misaligned LW
    run_op(0, 3'd2, 2'd0, 32'h1002, 32'h0, 32'h1234_5678, 5'd4, 1, 1, -1, 0, 0);
    // flush in the accept cycle: nothing accepted
    run_op(0, 3'd2, 2'd0, 32'h6000, 32'h0, 32'h0, 5'd5, 0, 0, -1, 0, 1);
    // flush and response in the same WAIT cycle
    run_op(0, 3'd2, 2'd0, 32'h7000, 32'h0, 32'h1111_2222, 5'd6, 0, 2, 2, 0, 0);
    // bus error on load and on store
    run_op(0, 3'd1, 2'd0, 32'h8000, 32'h0, 32'hFFFF_FFFF, 5'd8, 1, 1, -1, 1, 0);
    run_op(1, 3'd0, 2'd0, 32'h9001, 32'hA5, 32'h0, 5'd0, 0, 1, -1, 1, 0);
    // never granted: timeout out of REQ
    run_op(1, 3'd0, 2'd2, 32'hA000, 32'h1234_5678, 32'h0, 5'd0, TIMEOUT + 1, 0, -1, 0, 0);
    // LBU at lane 1
    run_op(0, 3'd4, 2'd0, 32'hB001, 32'h0, 32'h0000_9A00, 5'd10, 0, 1, -1, 0, 0);

    for (int n = 0; n < 250; n++) begin
      int g;
      int r;
      int kf;
      int rk;
      g  = ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, 2));
      r  = ($urandom_range(0, 7) == 0) ? TIMEOUT + 2 : int'($urandom_range(0, 2));
      kf = -1;
      if ($urandom_range(0, 5) == 0) begin
        rk = g + r;
        kf = int'($urandom_range(0, (rk < TIMEOUT - 2) ? rk : TIMEOUT - 2));
      end
      run_op(1'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
             5'($urandom), g, r, kf, ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

    // reset while waiting for a response
    check_idle();
    i_req_valid = 1'b1;
    i_req_we    = 1'b0;
    i_ld_type   = 3'd2;
    i_addr      = 32'hC000;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    i_dmem_gnt  = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_dmem_gnt = 1'b0;
    check("wait_stall", o_stall, 1);
    i_rstn = 1'b0;
    #1;
    check("mid_rst_stall", o_stall, 0);
    check("mid_rst_req", o_dmem_req, 0);
    check("mid_rst_addr", o_dmem_addr, 0);
    check("mid_rst_exc", o_exc_valid, 0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
    run_op(0, 3'd1, 2'd0, 32'hD002, 32'h0, 32'h7FFF_0000, 5'd11, 0, 0, -1, 0, 0);
    check_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aukv_lsu.md
# aukv_lsu

Parametrised load/store unit for the Auk-V memory-access stage. It replaces the fixed 32-bit, low-lane-only memory access logic with a configurable XLEN datapath. It adds byte-lane steering from the low address bits, a request/grant/response data-bus handshake, flush-safe draining of in-flight responses, a response timeout, and exception reporting. It sits between the execute stage and the data-memory port and feeds the writeback stage.

## Interface
Parameters:
- XLEN, 32, datapath and address width; legal values 32 or 64.
- TIMEOUT, 64, cycles allowed from request issue to response before a bus error is raised; minimum 2.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rstn  in  1  reset; asynchronous and active-low.
- i_req_valid  in  1  execute stage presents a memory op.
- i_req_we  in  1  1=store, 0=load.
- i_addr  in  XLEN  byte address.
- i_wdata  in  XLEN  store data, right-aligned.
- i_ld_type  in  3  000 LB, 001 LH, 010 LW, 011 LD (XLEN=64 only), 100 LBU, 101 LHU, 110 LWU (XLEN=64 only).
- i_st_type  in  2  00 SB, 01 SH, 10 SW, 11 SD (XLEN=64 only).
- i_rd  in  5  load destination register.
- i_flush  in  1  kill the accepted or in-flight op.
- o_stall  out  1  unit busy; upstream holds its op.
- o_dmem_req  out  1  bus request.
- o_dmem_we  out  1  bus write.
- o_dmem_addr  out  XLEN  address with the low log2(XLEN/8) bits cleared.
- o_dmem_wdata  out  XLEN  lane-steered store data.
- o_dmem_strb  out  XLEN/8  byte strobes; used for loads as well as stores.
- i_dmem_gnt  in  1  request accepted.
- i_dmem_rvalid  in  1  response (read data or write ack).
- i_dmem_rdata  in  XLEN  read data, full bus word.
- i_dmem_err  in  1  bus error, qualified by i_dmem_rvalid.
- o_wb_valid  out  1  one-cycle load-result pulse.
- o_wb_rd  out  5  destination register.
- o_wb_data  out  XLEN  extended load result.
- o_exc_valid  out  1  one-cycle exception pulse.
- o_exc_cause  out  2  01 misaligned load, 10 misaligned store, 11 bus error or timeout.
- o_exc_addr  out  XLEN  faulting byte address as presented.

## Operation
- State machine states: IDLE, REQ, WAIT, DRAIN.
- **IDLE:** accepts an op when i_req_valid=1 and i_flush=0.
  - Latches address, type, rd and steered data/strobes.
  - Moves to REQ, unless a misaligned trap fires (see Configuration).
- **REQ:** drives o_dmem_req=1 and holds all bus outputs stable until i_dmem_gnt=1.
  - gnt and rvalid in the same cycle: complete and go to IDLE.
  - gnt alone: go to WAIT.
  - i_flush before grant: drop the op and go to IDLE with no bus effect.
- **WAIT:** waits for i_dmem_rvalid, then goes to IDLE.
  - i_flush while in WAIT: go to DRAIN.
- **DRAIN:** consumes one i_dmem_rvalid, discards the data and any error, then goes to IDLE.
- **Store lane steering:** o_dmem_strb = base mask << addr[low bits].
  - Base masks: 1 for byte, 3 for half, F for word, FF for double.
  - o_dmem_wdata = i_wdata replicated across all lanes.
- **Load extraction:** i_dmem_rdata >> (8 × addr offset), then sign- or zero-extended to XLEN per i_ld_type.
- **Completion:**
  - Load with err=0: pulse o_wb_valid.
  - Store with err=0: no writeback.
  - err=1: pulse o_exc_valid, cause 11.
- **Timeout:** a counter clears on entry to REQ and increments in REQ and WAIT.
  - When it reaches TIMEOUT-1 without completion: exception cause 11, go to IDLE.
  - A late response is then ignored; this is a hazard the SoC fabric must avoid.
  - DRAIN does not time out.
- Illegal type encodings (LD/LWU/SD when XLEN=32, or 111) are treated as word-size accesses.

## Timing
- Reset values: state IDLE, all outputs 0, counter 0.
- All outputs are registered except o_stall, which decodes state != IDLE.
- Accept in cycle T → o_dmem_req=1 in T+1.
- Zero-wait response at T+1 → o_wb_valid in T+2, and o_stall drops in T+2.
- o_stall is 0 in the accept cycle; upstream advances after acceptance, and the next op is held while o_stall=1.
- o_wb_valid and o_exc_valid are never both high.
- i_flush and i_dmem_rvalid in the same WAIT cycle: the flush wins, the result is discarded, and the state goes to IDLE (the response counts as drained).
- Reset mid-transaction returns to IDLE immediately; the bus side must also be reset.

## Configuration
- Macro: AUKV_LSU_MISALIGN_TRAP_EN.
- **Defined:** an access whose address is not naturally aligned to its size is not issued.
  - The accept cycle is followed by an o_exc_valid pulse at T+1, cause 01 or 10, with o_exc_addr = i_addr.
  - The state stays IDLE.
- **Undefined:** the low address bits below the access size are forced to zero and the access proceeds normally; no misalignment exception exists.

## Test plan
- XLEN=32, LB at address 0x1003, rdata 0x80FFFFFF, zero-wait → strb 1000, o_wb_data 0xFFFFFF80 at T+2.
- SH at address 0x2002, wdata 0x0000BEEF, gnt delayed 3 cycles → strb 1100, wdata 0xBEEFBEEF held stable; o_stall high through the response cycle; no o_wb_valid.
- Load granted, then i_flush in WAIT, rvalid 2 cycles later with 0xDEADBEEF → no o_wb_valid; the next op is accepted the cycle after the drain.
- TIMEOUT=4, gnt given, no rvalid → o_exc_valid with cause 11 on the 4th cycle after REQ entry; o_stall returns to 0.
- With the macro defined, LW at address 0x1002 → o_dmem_req stays 0; o_exc_valid=1 with cause 01 and o_exc_addr 0x1002 at T+1.
- XLEN=64, LWU at address 0x...4, rdata 0xF0000000_00000000 → o_wb_data 0x00000000_F0000000.
